// File: rtl/circle_pkg.sv
// rtl/circle_pkg.sv - shared types, FSM encodings and widths for the circle rasteriser
package circle_pkg;
    localparam int XW_DEF  = 8;
    localparam int YW_DEF  = 7;
    localparam int RW_DEF  = 8;
    localparam int CRW     = ((XW_DEF > YW_DEF) ? XW_DEF : YW_DEF) + 2;
    localparam int DW      = RW_DEF + 2;
    localparam int SCREEN_W_DEF = 160;
    localparam int SCREEN_H_DEF = 120;

    typedef logic [2:0] state_t;
    localparam state_t IDLE   = 3'd0;
    localparam state_t OCT    = 3'd1;
    localparam state_t SPAN   = 3'd2;
    localparam state_t UPDATE = 3'd3;
    localparam state_t DONE   = 3'd4;

    typedef logic [2:0] octant_t;
    typedef logic [1:0] span_sel_t;
    typedef logic signed [CRW-1:0] coord_t;
    typedef logic signed [DW-1:0]  dist_t;
endpackage

// File: rtl/circle_span_walker.sv
// rtl/circle_span_walker.sv - clamps one horizontal span to window and screen, steps x left to right
module circle_span_walker
    import circle_pkg::*;
#(
    parameter int SCREEN_W = SCREEN_W_DEF,
    parameter int SCREEN_H = SCREEN_H_DEF,
    parameter int XW       = XW_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  step,
    input  logic signed [CRW-1:0] row,
    input  logic signed [CRW-1:0] left,
    input  logic signed [CRW-1:0] right,
    input  logic signed [CRW-1:0] win_x0,
    input  logic signed [CRW-1:0] win_x1,
    input  logic signed [CRW-1:0] win_y0,
    input  logic signed [CRW-1:0] win_y1,
    output logic [XW-1:0]         px,
    output logic                  empty,
    output logic                  last
);
    localparam coord_t X_MAX = coord_t'(SCREEN_W - 1);
    localparam coord_t Y_MAX = coord_t'(SCREEN_H - 1);

    coord_t lo, hi, cur, pos;
    logic   active;
    logic   row_ok;

    always_comb begin
        lo = left;
        if (win_x0 > lo) lo = win_x0;
        if (lo < coord_t'(0)) lo = coord_t'(0);
        hi = right;
        if (win_x1 < hi) hi = win_x1;
        if (hi > X_MAX) hi = X_MAX;
        row_ok = (row >= coord_t'(0)) && (row <= Y_MAX) && (row >= win_y0) && (row <= win_y1);
        empty  = !row_ok || (lo > hi);
        pos    = active ? cur : lo;
        last   = (pos >= hi);
        px     = pos[XW-1:0];
    end

    // The first pixel of a span comes straight from lo, so no load cycle is needed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur    <= '0;
            active <= 1'b0;
        end else if (step) begin
            if (last) begin
                active <= 1'b0;
            end else begin
                active <= 1'b1;
                cur    <= pos + coord_t'(1);
            end
        end
    end
endmodule

// File: rtl/circle_engine.sv
// rtl/circle_engine.sv - Bresenham outline/filled circle rasteriser; CIRCLE_DEDUP_EN drops duplicate points/spans
module circle_engine
    import circle_pkg::*;
#(
    parameter int SCREEN_W = SCREEN_W_DEF,
    parameter int SCREEN_H = SCREEN_H_DEF,
    parameter int XW       = XW_DEF,
    parameter int YW       = YW_DEF,
    parameter int RW       = RW_DEF,
    parameter int CW       = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          fill,
    input  logic [CW-1:0] colour,
    input  logic [XW-1:0] centre_x,
    input  logic [YW-1:0] centre_y,
    input  logic [RW-1:0] radius,
    input  logic [XW-1:0] clip_x0,
    input  logic [XW-1:0] clip_x1,
    input  logic [YW-1:0] clip_y0,
    input  logic [YW-1:0] clip_y1,
    input  logic          plot_ready,
    output logic          busy,
    output logic          done,
    output logic [XW-1:0] vga_x,
    output logic [YW-1:0] vga_y,
    output logic [CW-1:0] vga_colour,
    output logic          vga_plot
);
    localparam coord_t X_MAX = coord_t'(SCREEN_W - 1);
    localparam coord_t Y_MAX = coord_t'(SCREEN_H - 1);

    state_t        state;
    coord_t        x, y, cx, cy, wx0, wx1, wy0, wy1;
    dist_t         d, d_n;
    logic [CW-1:0] col;
    logic          fill_r;
    octant_t       oct, oct_next;
    span_sel_t     span, span_next;
    logic          oct_last, span_last, oct_inside;
    coord_t        ox, oy, row, left, right, x_n, y_n;
    logic          adv, w_step, w_empty, w_last;
    logic [XW-1:0] w_x;

    assign adv    = !vga_plot || plot_ready;
    assign busy   = (state == OCT) || (state == SPAN) || (state == UPDATE);
    assign done   = (state == DONE);
    assign w_step = adv && (state == SPAN) && !w_empty;

    always_comb begin
        ox = cx + x;
        oy = cy - y;
        case (oct)
            3'd0: begin ox = cx + x; oy = cy + y; end
            3'd1: begin ox = cx + y; oy = cy + x; end
            3'd2: begin ox = cx - y; oy = cy + x; end
            3'd3: begin ox = cx - x; oy = cy + y; end
            3'd4: begin ox = cx - x; oy = cy - y; end
            3'd5: begin ox = cx - y; oy = cy - x; end
            3'd6: begin ox = cx + y; oy = cy - x; end
            default: begin ox = cx + x; oy = cy - y; end
        endcase
        oct_inside = (ox >= coord_t'(0)) && (ox <= X_MAX) && (ox >= wx0) && (ox <= wx1) &&
                     (oy >= coord_t'(0)) && (oy <= Y_MAX) && (oy >= wy0) && (oy <= wy1);

        row   = (span == 2'd0) ? cy + y : (span == 2'd1) ? cy - y : (span == 2'd2) ? cy + x : cy - x;
        left  = span[1] ? cx - y : cx - x;
        right = span[1] ? cx + y : cx + x;

`ifdef CIRCLE_DEDUP_EN
        // Odd octants mirror their even partner whenever y==0 or x==y; r==0 collapses to one point.
        oct_last  = (x == coord_t'(0)) || ((y == coord_t'(0) || x == y) ? (oct == 3'd6) : (oct == 3'd7));
        oct_next  = oct + ((y == coord_t'(0) || x == y) ? octant_t'(2) : octant_t'(1));
        span_next = (span == 2'd0 && y == coord_t'(0)) ? 2'd2 : span + 2'd1;
        span_last = (span == 2'd3) ||
                    ((x == y) && ((span == 2'd1) || (span == 2'd0 && y == coord_t'(0))));
`else
        oct_last  = (oct == 3'd7);
        oct_next  = oct + octant_t'(1);
        span_next = span + 2'd1;
        span_last = (span == 2'd3);
`endif

        y_n = y + coord_t'(1);
        x_n = x;
        d_n = d + dist_t'((y_n <<< 1) + coord_t'(1));
        if (d > dist_t'(0)) begin
            x_n = x - coord_t'(1);
            d_n = d + dist_t'(((y_n - x_n) <<< 1) + coord_t'(1));
        end
    end

    circle_span_walker #(.SCREEN_W(SCREEN_W), .SCREEN_H(SCREEN_H), .XW(XW)) u_walker (
        .clk    (clk),
        .rst_n  (rst_n),
        .step   (w_step),
        .row    (row),
        .left   (left),
        .right  (right),
        .win_x0 (wx0),
        .win_x1 (wx1),
        .win_y0 (wy0),
        .win_y1 (wy1),
        .px     (w_x),
        .empty  (w_empty),
        .last   (w_last)
    );

    // Everything, outputs included, freezes while a plotted pixel waits for plot_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            x          <= '0;
            y          <= '0;
            d          <= '0;
            cx         <= '0;
            cy         <= '0;
            wx0        <= '0;
            wx1        <= '0;
            wy0        <= '0;
            wy1        <= '0;
            col        <= '0;
            fill_r     <= 1'b0;
            oct        <= '0;
            span       <= '0;
            vga_x      <= '0;
            vga_y      <= '0;
            vga_colour <= '0;
            vga_plot   <= 1'b0;
        end else if (adv) begin
            vga_plot <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    cx     <= coord_t'(centre_x);
                    cy     <= coord_t'(centre_y);
                    wx0    <= coord_t'(clip_x0);
                    wx1    <= coord_t'(clip_x1);
                    wy0    <= coord_t'(clip_y0);
                    wy1    <= coord_t'(clip_y1);
                    col    <= colour;
                    fill_r <= fill;
                    x      <= coord_t'(radius);
                    y      <= '0;
                    d      <= dist_t'(1) - dist_t'(radius);
                    oct    <= '0;
                    span   <= '0;
                    state  <= fill ? SPAN : OCT;
                end
                OCT: begin
                    vga_plot   <= oct_inside;
                    vga_x      <= ox[XW-1:0];
                    vga_y      <= oy[YW-1:0];
                    vga_colour <= col;
                    if (oct_last) begin
                        oct   <= '0;
                        state <= UPDATE;
                    end else begin
                        oct <= oct_next;
                    end
                end
                SPAN: begin
                    if (!w_empty) begin
                        vga_plot   <= 1'b1;
                        vga_x      <= w_x;
                        vga_y      <= row[YW-1:0];
                        vga_colour <= col;
                    end
                    if (w_empty || w_last) begin
                        if (span_last) begin
                            span  <= '0;
                            state <= UPDATE;
                        end else begin
                            span <= span_next;
                        end
                    end
                end
                UPDATE: begin
                    x     <= x_n;
                    y     <= y_n;
                    d     <= d_n;
                    state <= (y_n <= x_n) ? (fill_r ? SPAN : OCT) : DONE;
                end
                DONE: if (!start) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_circle_engine.sv
// tb/tb_circle_engine.sv - scoreboard bench for circle_engine
module tb_circle_engine;
    logic       clk = 1'b0;
    logic       rst_n, start, fill, plot_ready;
    logic [2:0] colour;
    logic [7:0] centre_x, clip_x0, clip_x1, radius;
    logic [6:0] centre_y, clip_y0, clip_y1;
    logic       busy, done, vga_plot;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;

    int n_checks = 0;
    int n_errors = 0;
    int exp_q[$];
    int wx0, wx1, wy0, wy1;

    always #5 clk = ~clk;

    circle_engine dut (
        .clk(clk), .rst_n(rst_n), .start(start), .fill(fill), .colour(colour),
        .centre_x(centre_x), .centre_y(centre_y), .radius(radius),
        .clip_x0(clip_x0), .clip_x1(clip_x1), .clip_y0(clip_y0), .clip_y1(clip_y1),
        .plot_ready(plot_ready), .busy(busy), .done(done),
        .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot)
    );

    task automatic check(input string tag, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic int pk(input int c, input int px, input int py);
        return (c << 16) | (px << 8) | py;
    endfunction

    function automatic void push_px(input int px, input int py, input int c);
        if (px >= 0 && px < 160 && py >= 0 && py < 120 &&
            px >= wx0 && px <= wx1 && py >= wy0 && py <= wy1)
            exp_q.push_back(pk(c, px, py));
    endfunction

    task automatic model(input int cx, input int cy, input int r, input bit f, input int c);
        int x, y, d, row, l, h;
        int px[8];
        int py[8];
        bit skip;
        x = r; y = 0; d = 1 - r;
        do begin
            if (!f) begin
                px = '{cx+x, cx+y, cx-y, cx-x, cx-x, cx-y, cx+y, cx+x};
                py = '{cy+y, cy+x, cy+x, cy+y, cy-y, cy-x, cy-x, cy-y};
                for (int o = 0; o < 8; o++) begin
                    skip = 1'b0;
`ifdef CIRCLE_DEDUP_EN
                    skip = (x == 0 && o != 0) || ((y == 0 || x == y) && (o % 2 == 1));
`endif
                    if (!skip) push_px(px[o], py[o], c);
                end
            end else begin
                for (int s = 0; s < 4; s++) begin
                    skip = 1'b0;
`ifdef CIRCLE_DEDUP_EN
                    skip = (s == 1 && y == 0) || (s >= 2 && x == y);
`endif
                    row = (s == 0) ? cy + y : (s == 1) ? cy - y : (s == 2) ? cy + x : cy - x;
                    l = (s < 2) ? cx - x : cx - y;
                    h = (s < 2) ? cx + x : cx + y;
                    if (!skip)
                        for (int p = l; p <= h; p++) push_px(p, row, c);
                end
            end
            y++;
            if (d <= 0) d += 2 * y + 1;
            else begin
                x--;
                d += 2 * (y - x) + 1;
            end
        end while (y <= x);
    endtask

    task automatic run_draw(input int cx, input int cy, input int r, input bit f, input int c,
                            input int x0, input int x1, input int y0, input int y1,
                            input bit rnd, input bit hold_start);
        int cycles;
        int hx, hy;
        bit held;
        cycles = 0;
        held = 1'b0;
        wx0 = x0; wx1 = x1; wy0 = y0; wy1 = y1;
        exp_q.delete();
        model(cx, cy, r, f, c);
        @(negedge clk);
        centre_x = 8'(cx); centre_y = 7'(cy); radius = 8'(r); fill = f; colour = 3'(c);
        clip_x0 = 8'(x0); clip_x1 = 8'(x1); clip_y0 = 7'(y0); clip_y1 = 7'(y1);
        plot_ready = 1'b1;
        start = 1'b1;
        @(negedge clk);
        if (!hold_start) start = 1'b0;
        centre_x = 8'(cx + 7); radius = 8'(r + 3); fill = ~f;
        check("busy_after_start", busy, 1);
        while (!done && cycles < 20000) begin
            plot_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (held) begin
                check("hold_plot", vga_plot, 1);
                check("hold_xy", pk(0, vga_x, vga_y), pk(0, hx, hy));
            end
            held = 1'b0;
            if (vga_plot) begin
                if (!plot_ready) begin
                    held = 1'b1;
                    hx = vga_x;
                    hy = vga_y;
                end else if (exp_q.size() == 0) begin
                    check("extra_pixel", pk(vga_colour, vga_x, vga_y), -1);
                end else begin
                    check("pixel", pk(vga_colour, vga_x, vga_y), exp_q.pop_front());
                end
            end
            @(negedge clk);
            cycles++;
        end
        check("no_timeout", int'(cycles < 20000), 1);
        check("missing_pixels", exp_q.size(), 0);
        check("busy_in_done", busy, 0);
        if (hold_start) begin
            @(negedge clk);
            check("done_held", done, 1);
            start = 1'b0;
        end
        @(negedge clk);
        check("done_cleared", done, 0);
        plot_ready = 1'b1;
    endtask

    initial begin
        int plots;
        rst_n = 1'b0; start = 1'b0; fill = 1'b0; plot_ready = 1'b1; colour = '0;
        centre_x = '0; centre_y = '0; radius = '0;
        clip_x0 = '0; clip_x1 = '0; clip_y0 = '0; clip_y1 = '0;
        repeat (2) @(negedge clk);
        check("rst_plot", vga_plot, 0);
        check("rst_busy_done", {busy, done}, 0);
        check("rst_xyc", pk(vga_colour, vga_x, vga_y), 0);
        rst_n = 1'b1;

        run_draw(80, 60, 10, 1'b0, 5, 0, 159, 0, 119, 1'b0, 1'b0);
        run_draw(2, 2, 5, 1'b0, 3, 0, 159, 0, 119, 1'b0, 1'b0);
        run_draw(10, 10, 3, 1'b1, 6, 9, 11, 0, 119, 1'b0, 1'b0);
        run_draw(80, 60, 10, 1'b0, 5, 0, 159, 0, 119, 1'b1, 1'b0);
        run_draw(80, 60, 6, 1'b1, 2, 0, 159, 0, 119, 1'b1, 1'b0);
        run_draw(5, 5, 0, 1'b0, 7, 0, 159, 0, 119, 1'b0, 1'b1);
        run_draw(80, 60, 4, 1'b0, 1, 100, 50, 0, 119, 1'b0, 1'b0);
        run_draw(80, 60, 4, 1'b1, 1, 0, 159, 90, 20, 1'b0, 1'b0);
        run_draw(150, 110, 15, 1'b1, 4, 0, 255, 0, 127, 1'b1, 1'b0);
        run_draw(150, 110, 15, 1'b0, 2, 140, 255, 100, 127, 1'b0, 1'b0);

        @(negedge clk);
        centre_x = 8'd80; centre_y = 7'd60; radius = 8'd20; fill = 1'b0; colour = 3'd3;
        clip_x0 = 8'd0; clip_x1 = 8'd159; clip_y0 = 7'd0; clip_y1 = 7'd119;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        check("mid_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_plot", vga_plot, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_xy", pk(vga_colour, vga_x, vga_y), 0);
        @(negedge clk);
        rst_n = 1'b1;
        plots = 0;
        repeat (30) begin
            @(negedge clk);
            if (vga_plot || busy || done) plots++;
        end
        check("mid_rst_idle", plots, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
